// File: rtl/vga_framebuffer.sv
// vga_framebuffer: 160x120 3-bit frame buffer that feeds the 8-colour VGA driver.
// The display side answers each fetch strobe with the pixel under the beam, with
// 4x upscaling. The host side writes through a valid/ready port. A clear FSM
// fills the buffer with one colour.
// Optional feature: define VGA_FB_CURSOR_EN to add an 8x8 hollow-square cursor overlay.
module vga_framebuffer #(
  parameter int FB_W    = 160,
  parameter int FB_H    = 120,
  parameter int H_TICKS = 1280,
  parameter int V_LINES = 480,
  parameter int H_SHIFT = 3,
  parameter int V_SHIFT = 2
) (
  input  logic        clk_50Mhz,
  input  logic        reset,
  input  logic        i_v_sync,
  input  logic        i_fetch_next_pixel,
`ifdef VGA_FB_CURSOR_EN
  input  logic [7:0]  i_cursor_x,
  input  logic [6:0]  i_cursor_y,
  input  logic [2:0]  i_cursor_color,
`endif
  output logic        o_pixel_r,
  output logic        o_pixel_g,
  output logic        o_pixel_b,
  input  logic        i_wr_valid,
  input  logic [14:0] i_wr_addr,
  input  logic [2:0]  i_wr_data,
  output logic        o_wr_ready,
  output logic        o_wr_oob,
  input  logic        i_clear,
  input  logic [2:0]  i_clear_color,
  output logic        o_clear_done
);

  localparam int FB_SIZE = FB_W * FB_H;
  localparam int HW      = $clog2(H_TICKS);
  localparam int LW      = $clog2(V_LINES);
  localparam logic [14:0] LAST_ADDR = 15'(FB_SIZE - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t          state_q, state_d;
  logic [14:0]     clr_addr_q, clr_addr_d;
  logic [2:0]      clr_color_q, clr_color_d;
  logic            done_q, done_d;
  logic            oob_q, oob_d;
  logic [HW-1:0]   h_tick_q, h_tick_d;
  logic [LW-1:0]   line_q, line_d;
  logic            v_q;
  logic [2:0]      pix_q, pix_d;
  logic [14:0]     rd_addr;
  logic            wr_fire;
  logic            we;
  logic [14:0]     waddr;
  logic [2:0]      wdata;

  logic [2:0]      mem [0:FB_SIZE-1];

`ifdef VGA_FB_CURSOR_EN
  // True when fb pixel (x,y) lies on the outline of the 8x8 square at (cx,cy).
  // 9/8-bit compares let the square run past the fb edge and simply clip.
  function automatic logic on_cursor(input logic [7:0] x, input logic [6:0] y,
                                     input logic [7:0] cx, input logic [6:0] cy);
    logic [8:0] x9, cx9;
    logic [7:0] y8, cy8;
    logic       in_x, in_y, edge_hit;
    x9       = {1'b0, x};
    cx9      = {1'b0, cx};
    y8       = {1'b0, y};
    cy8      = {1'b0, cy};
    in_x     = (x9 >= cx9) && (x9 <= cx9 + 9'd7);
    in_y     = (y8 >= cy8) && (y8 <= cy8 + 8'd7);
    edge_hit = (x9 == cx9) || (x9 == cx9 + 9'd7) || (y8 == cy8) || (y8 == cy8 + 8'd7);
    return in_x && in_y && edge_hit;
  endfunction
`endif

  // Fb address of the pixel under the beam: row from the line, column from the tick.
  assign rd_addr = 15'((int'(line_q) >> V_SHIFT) * FB_W + (int'(h_tick_q) >> H_SHIFT));

  assign o_wr_ready = (state_q == IDLE) && !reset;
  assign wr_fire    = i_wr_valid && o_wr_ready;

  // Beam counters advance per fetch; a v_sync falling edge restarts the frame and wins over a fetch.
  always_comb begin
    h_tick_d = h_tick_q;
    line_d   = line_q;
    if (v_q && !i_v_sync) begin
      h_tick_d = '0;
      line_d   = '0;
    end else if (i_fetch_next_pixel) begin
      if (h_tick_q == HW'(H_TICKS - 1)) begin
        h_tick_d = '0;
        line_d   = (line_q == LW'(V_LINES - 1)) ? '0 : line_q + LW'(1);
      end else begin
        h_tick_d = h_tick_q + HW'(1);
      end
    end
  end

  // Clear FSM next state: IDLE serves the host, CLEAR owns the write port for FB_SIZE cycles.
  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    clr_color_d = clr_color_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_clear) begin
          state_d     = CLEAR;
          clr_addr_d  = '0;
          clr_color_d = i_clear_color;
        end
      end
      CLEAR: begin
        if (clr_addr_q == LAST_ADDR) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          clr_addr_d = clr_addr_q + 15'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Single RAM write port shared by the clear engine and in-range host writes.
  always_comb begin
    we    = 1'b0;
    waddr = i_wr_addr;
    wdata = i_wr_data;
    oob_d = oob_q;
    if ((state_q == CLEAR) && !reset) begin
      we    = 1'b1;
      waddr = clr_addr_q;
      wdata = clr_color_q;
    end else if (wr_fire) begin
      if (i_wr_addr <= LAST_ADDR) begin
        we = 1'b1;
      end else begin
        oob_d = 1'b1;
      end
    end
  end

  // Display pixel: RAM data, optionally overridden by the cursor outline.
  always_comb begin
    pix_d = mem[rd_addr];
`ifdef VGA_FB_CURSOR_EN
    if (on_cursor(8'(h_tick_q >> H_SHIFT), 7'(line_q >> V_SHIFT), i_cursor_x, i_cursor_y)) begin
      pix_d = i_cursor_color;
    end
`endif
  end

  // Control registers: FSM state, sticky flags, beam counters and v_sync history.
  always_ff @(posedge clk_50Mhz) begin
    if (reset) begin
      state_q  <= IDLE;
      done_q   <= 1'b0;
      oob_q    <= 1'b0;
      h_tick_q <= '0;
      line_q   <= '0;
      v_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      oob_q    <= oob_d;
      h_tick_q <= h_tick_d;
      line_q   <= line_d;
      v_q      <= i_v_sync;
    end
  end

  // Clear address and colour only matter while CLEAR runs, so they carry no reset.
  always_ff @(posedge clk_50Mhz) begin
    clr_addr_q  <= clr_addr_d;
    clr_color_q <= clr_color_d;
  end

  // RAM write; the display read below sees the old word on a same-address collision.
  always_ff @(posedge clk_50Mhz) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Output register loaded only on a fetch, giving one cycle of read latency.
  always_ff @(posedge clk_50Mhz) begin
    if (reset) begin
      pix_q <= '0;
    end else if (i_fetch_next_pixel) begin
      pix_q <= pix_d;
    end
  end

  assign {o_pixel_r, o_pixel_g, o_pixel_b} = pix_q;
  assign o_wr_oob     = oob_q;
  assign o_clear_done = done_q;

endmodule

// File: tb/tb_vga_framebuffer.sv
// Bench for vga_framebuffer: table-driven vectors, hand sequences and a
// randomized phase, all compared against a frame-level reference model.
// A second, tiny instance makes whole-frame behaviour reachable in few cycles.
module tb_vga_framebuffer;

  localparam int FB_N  = 19200;
  localparam int FRAME = 1280 * 480;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        reset, v_sync, fetch, wr_valid, clear;
  logic [14:0] wr_addr;
  logic [2:0]  wr_data, clear_color;
  logic        pr, pg, pb, wr_ready, wr_oob, clear_done;
  logic        sr, sg, sb, s_ready, s_oob, s_done;
`ifdef VGA_FB_CURSOR_EN
  logic [7:0]  cur_x;
  logic [6:0]  cur_y;
  logic [2:0]  cur_col;
`endif

  vga_framebuffer dut (
    .clk_50Mhz(clk), .reset(reset), .i_v_sync(v_sync), .i_fetch_next_pixel(fetch),
`ifdef VGA_FB_CURSOR_EN
    .i_cursor_x(cur_x), .i_cursor_y(cur_y), .i_cursor_color(cur_col),
`endif
    .o_pixel_r(pr), .o_pixel_g(pg), .o_pixel_b(pb),
    .i_wr_valid(wr_valid), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .o_wr_ready(wr_ready), .o_wr_oob(wr_oob),
    .i_clear(clear), .i_clear_color(clear_color), .o_clear_done(clear_done)
  );

  // 4x3 fb, 32 ticks x 12 lines per frame
  vga_framebuffer #(.FB_W(4), .FB_H(3), .H_TICKS(32), .V_LINES(12)) u_small (
    .clk_50Mhz(clk), .reset(reset), .i_v_sync(v_sync), .i_fetch_next_pixel(fetch),
`ifdef VGA_FB_CURSOR_EN
    .i_cursor_x(cur_x), .i_cursor_y(cur_y), .i_cursor_color(cur_col),
`endif
    .o_pixel_r(sr), .o_pixel_g(sg), .o_pixel_b(sb),
    .i_wr_valid(wr_valid), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .o_wr_ready(s_ready), .o_wr_oob(s_oob),
    .i_clear(clear), .i_clear_color(clear_color), .o_clear_done(s_done)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state (frame-level view: beam is a tick count within the frame)
  logic [2:0] m_mem   [FB_N];
  bit         m_known [FB_N];
  int         m_pos;
  logic [2:0] m_pix;
  bit         m_pix_known;
  bit         m_oob, m_clr, m_done, m_vq;
  int         m_clr_idx;
  logic [2:0] m_clr_col;
  logic       last_ready;

  typedef struct {
    bit         vs;
    bit         fe;
    bit         chk;
    logic [2:0] exp;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int fb_addr(input int pos);
    int ln, tk;
    ln = pos / 1280;
    tk = pos % 1280;
    return (ln / 4) * 160 + tk / 8;
  endfunction

`ifdef VGA_FB_CURSOR_EN
  function automatic bit cursor_hit(input int pos);
    int x, y, cx, cy;
    x  = (pos % 1280) / 8;
    y  = (pos / 1280) / 4;
    cx = int'(cur_x);
    cy = int'(cur_y);
    if (x < cx || x > cx + 7 || y < cy || y > cy + 7) return 1'b0;
    return (x == cx) || (x == cx + 7) || (y == cy) || (y == cy + 7);
  endfunction
`endif

  // One clock: check ready, advance the model with the current inputs, clock, check outputs.
  task automatic step();
    int a;
    #1;
    last_ready = wr_ready;
    check("wr_ready", wr_ready, !reset && !m_clr);
    if (reset) begin
      m_pos = 0; m_pix = 3'b000; m_pix_known = 1'b1;
      m_oob = 1'b0; m_clr = 1'b0; m_done = 1'b0; m_vq = 1'b0;
    end else begin
      a = fb_addr(m_pos);
      if (fetch) begin
        m_pix       = m_mem[a];
        m_pix_known = m_known[a];
`ifdef VGA_FB_CURSOR_EN
        if (cursor_hit(m_pos)) begin
          m_pix = cur_col; m_pix_known = 1'b1;
        end
`endif
      end
      if (m_vq && !v_sync) m_pos = 0;
      else if (fetch) m_pos = (m_pos + 1) % FRAME;
      m_done = 1'b0;
      if (m_clr) begin
        m_mem[m_clr_idx] = m_clr_col;
        m_known[m_clr_idx] = 1'b1;
        m_clr_idx++;
        if (m_clr_idx == FB_N) begin
          m_clr = 1'b0; m_done = 1'b1;
        end
      end else begin
        if (wr_valid) begin
          if (int'(wr_addr) < FB_N) begin
            m_mem[wr_addr] = wr_data; m_known[wr_addr] = 1'b1;
          end else m_oob = 1'b1;
        end
        if (clear) begin
          m_clr = 1'b1; m_clr_idx = 0; m_clr_col = clear_color;
        end
      end
      m_vq = v_sync;
    end
    @(posedge clk);
    #1;
    if (m_pix_known) check("pixel", {pr, pg, pb}, m_pix);
    check("wr_oob", wr_oob, m_oob);
    check("clear_done", clear_done, m_done);
  endtask

  task automatic wr(input int addr, input logic [2:0] data);
    wr_valid = 1'b1; wr_addr = 15'(addr); wr_data = data;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic resync();
    v_sync = 1'b1; step();
    v_sync = 1'b0; step();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, s_cnt;
    bit seen;
    logic [2:0] old0;

    // Table: resync, 16 fetches across fb pixels 0 and 1, then 5 idle cycles holding.
    tbl.push_back('{vs: 1'b1, fe: 1'b0, chk: 1'b0, exp: 3'b000});
    tbl.push_back('{vs: 1'b0, fe: 1'b0, chk: 1'b0, exp: 3'b000});
    for (int i = 0; i < 16; i++) tbl.push_back('{vs: 1'b0, fe: 1'b1, chk: 1'b1, exp: (i < 8) ? 3'b100 : 3'b010});
    for (int i = 0; i < 5; i++)  tbl.push_back('{vs: 1'b0, fe: 1'b0, chk: 1'b1, exp: 3'b010});

    reset = 1'b1; v_sync = 1'b0; fetch = 1'b0; wr_valid = 1'b0; wr_addr = '0;
    wr_data = '0; clear = 1'b0; clear_color = '0;
`ifdef VGA_FB_CURSOR_EN
    cur_x = 8'd200; cur_y = 7'd127; cur_col = 3'b111;
`endif
    repeat (3) step();
    check("reset_pixel", {pr, pg, pb}, 3'b000);
    check("reset_oob", wr_oob, 1'b0);
    check("reset_done", clear_done, 1'b0);
    check("ready_in_reset", wr_ready, 1'b0);
    reset = 1'b0;

    wr(0, 3'b100); wr(19199, 3'b011); wr(1, 3'b010); wr(11, 3'b011);

    foreach (tbl[i]) begin
      v_sync = tbl[i].vs; fetch = tbl[i].fe;
      step();
      if (tbl[i].chk) begin
        check("tbl_pixel", {pr, pg, pb}, tbl[i].exp);
        check("tbl_small_pixel", {sr, sg, sb}, tbl[i].exp);
      end
    end
    v_sync = 1'b0; fetch = 1'b0;

    // Small instance: last fetch of the last line reads the last address, then wraps to 0.
    resync();
    fetch = 1'b1;
    for (int i = 1; i <= 384; i++) begin
      step();
      if (i == 384) check("small_last_pixel", {sr, sg, sb}, 3'b011);
    end
    step();
    check("small_wrap_pixel", {sr, sg, sb}, 3'b100);
    fetch = 1'b0;

    // Randomized traffic with occasional frame resyncs and same-address collisions.
    for (int i = 0; i < 3000; i++) begin
      fetch    = ($urandom_range(0, 9) < 7);
      wr_valid = $urandom_range(0, 1) == 1;
      wr_addr  = 15'($urandom_range(0, 319));
      if ($urandom_range(0, 7) == 0) wr_addr = 15'(fb_addr(m_pos));
      wr_data  = 3'($urandom);
      v_sync   = ($urandom_range(0, 499) == 0);
      step();
    end
    fetch = 1'b0; wr_valid = 1'b0; v_sync = 1'b0;
    step();

    // 300 fetches, then a v_sync falling edge coinciding with a fetch: next fetch is addr 0.
    fetch = 1'b1;
    repeat (300) step();
    resync();
    step();
    check("resync_addr0", {pr, pg, pb}, m_mem[0]);
    fetch = 1'b0;

    // Out-of-range write: sticky flag, RAM untouched.
    old0 = m_mem[0];
    wr(19200, 3'b111);
    check("oob_set", wr_oob, 1'b1);
    check("small_oob_set", s_oob, 1'b1);
    repeat (3) step();
    check("oob_sticky", wr_oob, 1'b1);
    resync();
    fetch = 1'b1; step(); fetch = 1'b0;
    check("oob_addr0_kept", {pr, pg, pb}, old0);
    reset = 1'b1; step(); reset = 1'b0;
    check("oob_cleared", wr_oob, 1'b0);

    // Full clear to 3'b101; a write and a second i_clear during the clear are ignored.
    clear_color = 3'b101; clear = 1'b1; step(); clear = 1'b0;
    cnt = 0; s_cnt = 0; seen = 1'b0;
    for (int i = 0; i < 20000 && !seen; i++) begin
      wr_valid = (i == 5); wr_addr = '0; wr_data = 3'b010;
      clear = (i == 10);
      step();
      if (!last_ready) cnt++;
      if (s_done) s_cnt++;
      if (clear_done) seen = 1'b1;
    end
    wr_valid = 1'b0; clear = 1'b0;
    check("clear_ready_low_cycles", cnt, 19200);
    check("clear_done_seen", seen, 1'b1);
    check("small_done_pulses", s_cnt, 1);
    step();
    check("clear_done_once", clear_done, 1'b0);
    check("small_ready_idle", s_ready, 1'b1);

    resync();
    fetch = 1'b1;
    for (int i = 0; i < 384; i++) begin
      step();
      check("small_frame_cleared", {sr, sg, sb}, 3'b101);
      if (i == 0) check("clear_addr0", {pr, pg, pb}, 3'b101);
    end
    fetch = 1'b0;

    // Reset at clr_addr 5000: back to IDLE, no completion pulse.
    clear_color = 3'b000; clear = 1'b1; step(); clear = 1'b0;
    repeat (5000) step();
    reset = 1'b1; step();
    check("midclear_no_done", clear_done, 1'b0);
    reset = 1'b0;
    step();
    check("ready_after_reset", last_ready, 1'b1);
    repeat (3) step();
    check("midclear_still_no_done", clear_done, 1'b0);

`ifdef VGA_FB_CURSOR_EN
    // Cursor at (10,0) over the partially cleared 3'b000 rows.
    cur_x = 8'd10; cur_y = 7'd0; cur_col = 3'b111;
    resync();
    fetch = 1'b1;
    for (int p = 0; p <= 5208; p++) begin
      step();
      if (p >= 80 && p <= 143) check("cursor_top_edge", {pr, pg, pb}, 3'b111);
      if (p == 79 || p == 5208) check("cursor_outside", {pr, pg, pb}, 3'b000);
    end
    fetch = 1'b0;
    cur_x = 8'd200; cur_y = 7'd127;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
